// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM/WB handshake, data-SRAM response and forwarding signals of the MEM stage
interface mem_stage_if;
    logic        mem_allowin;
    logic        ex_to_mem_valid;
    logic [91:0] ex_to_mem_zip;
    logic        ex_req_inflight;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [86:0] mem_to_wb_zip;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_flush;
    logic [38:0] mem_rf_zip;
    logic        mem_ex_or_ertn;

    // Drives MEM (EX, WB and the data SRAM seen together)
    modport master (
        output ex_to_mem_valid, ex_to_mem_zip, ex_req_inflight, wb_allowin,
               data_sram_data_ok, data_sram_rdata, wb_flush,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex_or_ertn
    );

    // The MEM stage itself
    modport slave (
        input  ex_to_mem_valid, ex_to_mem_zip, ex_req_inflight, wb_allowin,
               data_sram_data_ok, data_sram_rdata, wb_flush,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_zip, mem_rf_zip, mem_ex_or_ertn
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: waits for load/store data responses, extends load data, hands off to WB, drops stale responses
module mem_stage (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus
);
    logic        mem_valid;
    logic        buf_valid;
    logic [1:0]  discard_cnt;
    logic [91:0] mem_zip;
    logic [31:0] rdata_buf;

    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic        mem_req_issued;
    logic        ex_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        is_ertn;

    logic        need_resp;
    logic        resp_here;
    logic        ready_go;
    logic        capture;
    logic        leave;
    logic        buf_load;
    logic        own;
    logic        drop;
    logic [2:0]  cnt_inc;
    logic [2:0]  cnt_sum;
    logic [1:0]  cnt_next;
    logic [31:0] src_word;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] final_wdata;
    logic        fwd_we;
    logic        load_pending;

    assign {pc, alu_result, rf_we, rf_waddr, res_from_mem, ld_op, mem_req_issued,
            ex_valid, ecode, esubcode, is_ertn} = mem_zip;

    // An instruction already carrying an exception never waits for its data
    assign need_resp = mem_req_issued & ~ex_valid;
    // A response only belongs to MEM once every stale response has been drained
    assign resp_here = bus.data_sram_data_ok & (discard_cnt == 2'd0);
    assign ready_go  = ~need_resp | resp_here | buf_valid;
    assign drop      = bus.data_sram_data_ok & (discard_cnt != 2'd0);

    assign bus.mem_allowin     = ~mem_valid | (ready_go & bus.wb_allowin);
    assign bus.mem_to_wb_valid = mem_valid & ready_go & ~bus.wb_flush;

    assign capture  = bus.ex_to_mem_valid & bus.mem_allowin & ~bus.wb_flush;
    assign leave    = bus.mem_to_wb_valid & bus.wb_allowin;
    // Hold the response when WB stalls, since the SRAM presents it for one cycle only
    assign buf_load = mem_valid & need_resp & resp_here & ~buf_valid & ~bus.wb_allowin & ~bus.wb_flush;
    // The MEM instruction still owes a response that will arrive after it is flushed
    assign own      = mem_valid & need_resp & ~resp_here & ~buf_valid;

    // Stale-response count: flush adds the outstanding ones, each dropped response removes one
    always_comb begin
        cnt_inc  = bus.wb_flush ? 3'(own) + 3'(bus.ex_req_inflight) : 3'd0;
        cnt_sum  = 3'(discard_cnt) + cnt_inc - 3'(drop);
        cnt_next = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end

    // Align the addressed byte/halfword to bit 0, then extend per load kind
    always_comb begin
        src_word    = buf_valid ? rdata_buf : bus.data_sram_rdata;
        shifted     = src_word >> {alu_result[1:0], 3'b000};
        load_data   = (ld_op == 3'd1) ? {{24{shifted[7]}}, shifted[7:0]} :
                      (ld_op == 3'd2) ? {{16{shifted[15]}}, shifted[15:0]} :
                      (ld_op == 3'd3) ? {24'd0, shifted[7:0]} :
                      (ld_op == 3'd4) ? {16'd0, shifted[15:0]} :
                                        shifted;
        final_wdata = res_from_mem ? load_data : alu_result;
    end

    assign fwd_we       = mem_valid & rf_we & ~ex_valid & ~is_ertn;
    assign load_pending = mem_valid & res_from_mem & ~ready_go;

    assign bus.mem_to_wb_zip  = {rf_we, rf_waddr, final_wdata, pc, ex_valid, ecode, esubcode, is_ertn};
    assign bus.mem_rf_zip     = {fwd_we, load_pending, rf_waddr, final_wdata};
    assign bus.mem_ex_or_ertn = mem_valid & (ex_valid | is_ertn);

    // Stage occupancy: flush empties MEM, otherwise refill whenever MEM can accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            mem_valid <= 1'b0;
        else if (bus.wb_flush)
            mem_valid <= 1'b0;
        else if (bus.mem_allowin)
            mem_valid <= bus.ex_to_mem_valid;
    end

    // Captured instruction record from EX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            mem_zip <= 92'd0;
        else if (capture)
            mem_zip <= bus.ex_to_mem_zip;
    end

    // Response buffer, released when the instruction leaves or is flushed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else if (bus.wb_flush || leave) begin
            buf_valid <= 1'b0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            rdata_buf <= bus.data_sram_rdata;
        end
    end

    // Stale-response counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            discard_cnt <= 2'd0;
        else
            discard_cnt <= cnt_next;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized EX/WB/SRAM traffic against a transaction-level scoreboard
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [91:0] zip;
        logic [86:0] wb;
        logic        need;
        logic        got;
    } ins_t;

    typedef struct {
        int          id;
        logic        dead;
        logic [31:0] data;
    } rsp_t;

    ins_t mq[$];
    rsp_t sq[$];
    ins_t ex_ins;
    logic ex_has = 1'b0;
    int   next_id = 0;

    function automatic logic [91:0] mk(logic [31:0] pc, logic [31:0] alu, logic we, logic [4:0] wa,
                                       logic rfm, logic [2:0] op, logic iss, logic exv,
                                       logic [5:0] ec, logic [8:0] es, logic er);
        return {pc, alu, we, wa, rfm, op, iss, exv, ec, es, er};
    endfunction

    function automatic logic [31:0] ld_ext(logic [31:0] w, logic [1:0] off, logic [2:0] op);
        longint v = longint'(w) / (longint'(1) << (8 * off));
        longint b = v % 256;
        longint h = v % 65536;
        case (op)
            3'd1:    return 32'(b >= 128 ? b - 256 : b);
            3'd2:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd3:    return 32'(b);
            3'd4:    return 32'(h);
            default: return 32'(v);
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_allowin"}, bus.mem_allowin, 1'b1);
        check({tag, "_valid"}, bus.mem_to_wb_valid, 1'b0);
        check({tag, "_zip"}, bus.mem_to_wb_zip, 87'd0);
        check({tag, "_rfzip"}, bus.mem_rf_zip, 39'd0);
        check({tag, "_exertn"}, bus.mem_ex_or_ertn, 1'b0);
    endtask

    task automatic new_ins();
        int          k = $urandom_range(0, 9);
        logic        ld = (k < 5);
        logic        st = (k == 5) || (k == 6);
        logic        exc = (k == 8);
        logic        ert = (k == 9);
        logic [31:0] pc = $urandom;
        logic [31:0] alu = $urandom;
        logic [31:0] data = $urandom;
        logic [2:0]  op = 3'($urandom_range(0, 7));
        logic [4:0]  wa = 5'($urandom);
        logic [5:0]  ec = 6'($urandom);
        logic [8:0]  es = 9'($urandom);
        logic        we = ld | (((k == 7) | exc) & 1'($urandom));
        logic        iss = ld | st | (exc & 1'($urandom));
        logic [31:0] wd = ld ? ld_ext(data, alu[1:0], op) : alu;
        ex_ins.id   = next_id;
        ex_ins.zip  = mk(pc, alu, we, wa, ld, op, iss, exc, ec, es, ert);
        ex_ins.wb   = {we, wa, wd, pc, exc, ec, es, ert};
        ex_ins.need = iss & ~exc;
        ex_ins.got  = 1'b0;
        if (ex_ins.need)
            sq.push_back('{id: next_id, dead: 1'b0, data: data});
        next_id++;
        ex_has = 1'b1;
    endtask

    initial begin
        logic        front;
        logic        rdy;
        logic        ev;
        logic        ea;
        logic        nodead;
        logic        gen;
        logic [95:0] junk;
        ins_t        f;

        bus.ex_to_mem_valid   = 1'b0;
        bus.ex_to_mem_zip     = 92'd0;
        bus.ex_req_inflight   = 1'b0;
        bus.wb_allowin        = 1'b1;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'd0;
        bus.wb_flush          = 1'b0;

        @(negedge clk); #4;
        check_reset("reset");
        @(negedge clk);
        resetn = 1'b1;

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0010, 32'h1003, 1'b1, 5'd7, 1'b1, 3'd1, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        #4; check("t1_allowin", bus.mem_allowin, 1'b1);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b0;
        #4; check("t1_pending", bus.mem_rf_zip[37], 1'b1);
        check("t1_wait", bus.mem_to_wb_valid, 1'b0);
        check("t1_stall", bus.mem_allowin, 1'b0);
        @(negedge clk);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h80AA_BBCC;
        #4; check("t1_valid", bus.mem_to_wb_valid, 1'b1);
        check("t1_wdata", bus.mem_to_wb_zip[80:49], 32'hFFFF_FF80);
        check("t1_nopend", bus.mem_rf_zip[37], 1'b0);
        @(negedge clk);
        bus.data_sram_data_ok = 1'b0;
        #4; check("t1_once", bus.mem_to_wb_valid, 1'b0);
        check("t1_free", bus.mem_allowin, 1'b1);
        @(negedge clk);

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0020, 32'h2002, 1'b1, 5'd9, 1'b1, 3'd4, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid   = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h9ABC_1234;
        bus.wb_allowin        = 1'b0;
        #4; check("t2_valid", bus.mem_to_wb_valid, 1'b1);
        check("t2_wdata", bus.mem_to_wb_zip[80:49], 32'h0000_9ABC);
        check("t2_stall", bus.mem_allowin, 1'b0);
        @(negedge clk);
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'hDEAD_BEEF;
        #4; check("t2_buf1", bus.mem_to_wb_zip[80:49], 32'h0000_9ABC);
        check("t2_stall1", bus.mem_allowin, 1'b0);
        @(negedge clk);
        #4; check("t2_buf2", bus.mem_to_wb_zip[80:49], 32'h0000_9ABC);
        check("t2_hold", bus.mem_to_wb_valid, 1'b1);
        @(negedge clk);
        bus.wb_allowin = 1'b1;
        #4; check("t2_hand", bus.mem_to_wb_zip[80:49], 32'h0000_9ABC);
        check("t2_allowin", bus.mem_allowin, 1'b1);
        @(negedge clk);
        #4; check("t2_gone", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0030, 32'h3000, 1'b1, 5'd3, 1'b1, 3'd0, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b0;
        bus.wb_flush        = 1'b1;
        bus.ex_req_inflight = 1'b1;
        #4; check("t3_flushout", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);
        bus.wb_flush        = 1'b0;
        bus.ex_req_inflight = 1'b0;
        #4; check("t3_empty", bus.mem_allowin, 1'b1);
        check("t3_cnt", dut.discard_cnt, 2'd2);
        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0040, 32'h4000, 1'b1, 5'd4, 1'b1, 3'd0, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid   = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1111_1111;
        #4; check("t3_drop1", bus.mem_to_wb_valid, 1'b0);
        check("t3_pend", bus.mem_rf_zip[37], 1'b1);
        @(negedge clk);
        bus.data_sram_rdata = 32'h2222_2222;
        #4; check("t3_drop2", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);
        bus.data_sram_rdata = 32'h3333_3333;
        #4; check("t3_valid", bus.mem_to_wb_valid, 1'b1);
        check("t3_wdata", bus.mem_to_wb_zip[80:49], 32'h3333_3333);
        @(negedge clk);
        bus.data_sram_data_ok = 1'b0;
        #4; check("t3_gone", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0050, 32'h5000, 1'b1, 5'd2, 1'b1, 3'd0, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid   = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h5555_5555;
        bus.wb_flush          = 1'b1;
        #4; check("t4_novalid", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);
        bus.data_sram_data_ok = 1'b0;
        bus.wb_flush          = 1'b0;
        #4; check("t4_cnt", dut.discard_cnt, 2'd0);
        check("t4_empty", bus.mem_allowin, 1'b1);

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0060, 32'h1234, 1'b1, 5'd5, 1'b0, 3'd0, 1'b0, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b0;
        #4; check("t5_valid", bus.mem_to_wb_valid, 1'b1);
        check("t5_rfzip", bus.mem_rf_zip, {1'b1, 1'b0, 5'd5, 32'h1234});
        check("t5_allowin", bus.mem_allowin, 1'b1);
        @(negedge clk);
        #4; check("t5_gone", bus.mem_to_wb_valid, 1'b0);
        @(negedge clk);

        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0070, 32'h7000, 1'b1, 5'd6, 1'b0, 3'd0, 1'b1, 1'b1, 6'h08, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b0;
        #4; check("t6_valid", bus.mem_to_wb_valid, 1'b1);
        check("t6_exertn", bus.mem_ex_or_ertn, 1'b1);
        check("t6_fwd", bus.mem_rf_zip[38], 1'b0);
        check("t6_ecode", bus.mem_to_wb_zip[15:10], 6'h08);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b1;
        bus.ex_to_mem_zip   = mk(32'h1c00_0080, 32'h8000, 1'b1, 5'd8, 1'b1, 3'd0, 1'b1, 1'b0, 6'd0, 9'd0, 1'b0);
        @(negedge clk);
        bus.ex_to_mem_valid = 1'b0;
        #1; check("t6_pend", bus.mem_rf_zip[37], 1'b1);
        #1; resetn = 1'b0;
        #1; check_reset("t6_rst");
        @(negedge clk);
        resetn = 1'b1;

        for (int c = 0; c < 3300; c++) begin
            gen = (c < 3000);
            if (!ex_has && gen && $urandom_range(0, 3) != 0)
                new_ins();
            junk = {$urandom, $urandom, $urandom};
            nodead = 1'b1;
            foreach (sq[i]) if (sq[i].dead) nodead = 1'b0;
            bus.ex_to_mem_valid = ex_has;
            bus.ex_to_mem_zip   = ex_has ? ex_ins.zip : junk[91:0];
            bus.ex_req_inflight = ex_has & ex_ins.need;
            bus.wb_allowin      = gen ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.wb_flush        = gen && nodead && ($urandom_range(0, 19) == 0);
            if (sq.size() > 0 && (sq[0].dead || (mq.size() > 0 && sq[0].id == mq[0].id)) && $urandom_range(0, 1) == 1) begin
                bus.data_sram_data_ok = 1'b1;
                bus.data_sram_rdata   = sq[0].data;
            end else begin
                bus.data_sram_data_ok = 1'b0;
                bus.data_sram_rdata   = $urandom;
            end
            #4;
            front = (mq.size() > 0);
            f = front ? mq[0] : ex_ins;
            rdy = front && (!f.need || f.got || (bus.data_sram_data_ok && !sq[0].dead));
            ev = rdy && !bus.wb_flush;
            ea = !front || (rdy && bus.wb_allowin);
            check("r_valid", bus.mem_to_wb_valid, ev);
            check("r_allowin", bus.mem_allowin, ea);
            check("r_exertn", bus.mem_ex_or_ertn, front && (f.zip[16] || f.zip[0]));
            check("r_fwd", bus.mem_rf_zip[38], front && f.zip[27] && !f.zip[16] && !f.zip[0]);
            check("r_pend", bus.mem_rf_zip[37], front && f.zip[21] && !rdy);
            if (bus.data_sram_data_ok) begin
                if (!sq[0].dead)
                    mq[0].got = 1'b1;
                void'(sq.pop_front());
            end
            if (ev && bus.wb_allowin) begin
                check("r_zip", bus.mem_to_wb_zip, f.wb);
                void'(mq.pop_front());
            end
            if (bus.wb_flush) begin
                mq.delete();
                foreach (sq[i]) sq[i].dead = 1'b1;
                ex_has = 1'b0;
            end else if (ex_has && ea) begin
                mq.push_back(ex_ins);
                ex_has = 1'b0;
            end
            @(negedge clk);
            if (!gen && mq.size() == 0 && sq.size() == 0 && !ex_has)
                break;
        end
        check("drain", {mq.size() == 0, sq.size() == 0, ex_has}, {1'b1, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
